bs4_seq_shifter: RTL and testbench

Iterative, registered 4-bit shift/rotate unit. It sits directly upstream of the 4-bit 2:1 mux select stage and supplies the shifted operand word to it. One start request loads a word, applies one single-bit shift per clock for the requested amount, and presents a held result with a one-cycle done strobe. Provides the sequential control that the combinational mux stage lacks.

---
 rtl/bs4_seq_shifter_if.sv | 26 ++
 rtl/bs4_seq_shifter.sv | 104 ++++++++++
 tb/tb_bs4_seq_shifter.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/bs4_seq_shifter_if.sv
// Request/result bundle for the iterative shift/rotate unit.
// The master drives the request fields; the slave returns busy/done/dout.
interface bs4_seq_shifter_if #(
    parameter int WIDTH = 4,
    parameter int AMT_W = 2
);
    logic             start;
    logic [WIDTH-1:0] din;
    logic [AMT_W-1:0] amt;
    logic             dir;
    logic             rot;
    logic             arith;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] dout;

    modport master (
        output start, din, amt, dir, rot, arith,
        input  busy, done, dout
    );

    modport slave (
        input  start, din, amt, dir, rot, arith,
        output busy, done, dout
    );
endinterface

// File: rtl/bs4_seq_shifter.sv
// Iterative shift/rotate unit: one single-bit step per clock, held result with done strobe.
// Optional sign-fill right shift is enabled by defining BS4_ARITH_SHIFT_EN.
//
// state | meaning
// IDLE  | waiting for start
// SHIFT | one single-bit step per clock, count holds steps remaining
// DONE  | one-cycle result strobe; start here chains the next operation
module bs4_seq_shifter #(
    parameter int WIDTH = 4,
    parameter int AMT_W = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    bs4_seq_shifter_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sreg;
    logic [AMT_W-1:0] count;
    logic             dir_q;
    logic             rot_q;
    logic [WIDTH-1:0] dout_q;
    logic             fill;

    // fill is the bit entering the MSB on a non-rotating right step
`ifdef BS4_ARITH_SHIFT_EN
    logic arith_q;
    assign fill = arith_q & sreg[WIDTH-1];
`else
    logic unused_arith;
    assign unused_arith = bus.arith;
    assign fill         = 1'b0;
`endif

    function automatic logic [WIDTH-1:0] step(
        input logic [WIDTH-1:0] q,
        input logic             d,
        input logic             r,
        input logic             f
    );
        logic [WIDTH-1:0] res;
        res = q;
        if (r) begin
            res = d ? {q[0], q[WIDTH-1:1]} : {q[WIDTH-2:0], q[WIDTH-1]};
        end else begin
            res = d ? {f, q[WIDTH-1:1]} : {q[WIDTH-2:0], 1'b0};
        end
        return res;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            sreg    <= '0;
            count   <= '0;
            dir_q   <= 1'b0;
            rot_q   <= 1'b0;
            dout_q  <= '0;
`ifdef BS4_ARITH_SHIFT_EN
            arith_q <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        sreg  <= bus.din;
                        count <= bus.amt;
                        dir_q <= bus.dir;
                        rot_q <= bus.rot;
`ifdef BS4_ARITH_SHIFT_EN
                        arith_q <= bus.arith;
`endif
                        if (bus.amt == '0) begin
                            dout_q <= bus.din;
                            state  <= DONE;
                        end else begin
                            state  <= SHIFT;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                SHIFT: begin
                    sreg  <= step(sreg, dir_q, rot_q, fill);
                    count <= count - AMT_W'(1);
                    if (count == AMT_W'(1)) begin
                        dout_q <= step(sreg, dir_q, rot_q, fill);
                        state  <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy = (state == SHIFT);
    assign bus.done = (state == DONE);
    assign bus.dout = dout_q;
endmodule

// File: tb/tb_bs4_seq_shifter.sv
// Scoreboard bench for bs4_seq_shifter: driver pushes model results, monitor checks on done.
module tb_bs4_seq_shifter;
    localparam int W = 4;

    logic clk;
    logic rst_n;
    int   cyc;
    int   total;
    int   bad;

    bs4_seq_shifter_if #(.WIDTH(4), .AMT_W(2)) bus ();

    bs4_seq_shifter #(.WIDTH(4), .AMT_W(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [3:0] d;
        int         cyc;
        int         amt;
    } exp_t;

    exp_t sb[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input int got, input int expv);
        total++;
        if (got != expv) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", nm, got, expv);
        end
    endtask

    // Reference: whole-operation result from shift arithmetic on integers.
    function automatic logic [3:0] model(input logic [3:0] d, input int k,
                                         input bit dr, input bit rt, input bit ar);
        int v;
        int s;
        int r;
        v = int'(d);
        if (rt)
            r = dr ? ((v >> k) | (v << (W - k))) : ((v << k) | (v >> (W - k)));
        else if (!dr)
            r = v << k;
`ifdef BS4_ARITH_SHIFT_EN
        else if (ar) begin
            s = (v ^ 8) - 8;
            r = s >>> k;
        end
`endif
        else
            r = v >> k;
        s = ar ? 0 : 0;
        return r[3:0];
    endfunction

    always @(negedge clk) begin : monitor
        static logic [3:0] held = 4'd0;
        static int         run  = 0;
        exp_t              e;
        if (!rst_n) begin
            held = 4'd0;
            run  = 0;
        end else begin
            if (bus.busy) run++;
            if (bus.done) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done dout=%0d cyc=%0d", bus.dout, cyc);
                end else begin
                    e = sb.pop_front();
                    check("dout", int'(bus.dout), int'(e.d));
                    check("latency", cyc, e.cyc + e.amt + 1);
                    check("busy_cycles", run, e.amt);
                    held = e.d;
                end
                run = 0;
            end else begin
                check("dout_held", int'(bus.dout), int'(held));
            end
        end
    end

    // Called just after a rising edge with the DUT in IDLE or DONE; returns in the DONE cycle.
    task automatic issue(input logic [3:0] d, input int a, input bit dr, input bit rt,
                         input bit ar, input bit noise);
        exp_t e;
        e.d   = model(d, a, dr, rt, ar);
        e.cyc = cyc;
        e.amt = a;
        sb.push_back(e);
        bus.start = 1'b1;
        bus.din   = d;
        bus.amt   = 2'(a);
        bus.dir   = dr;
        bus.rot   = rt;
        bus.arith = ar;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int i = 0; i < a; i++) begin
            bus.din   = 4'($urandom);
            bus.amt   = 2'($urandom);
            bus.dir   = 1'($urandom);
            bus.rot   = 1'($urandom);
            bus.arith = 1'($urandom);
            bus.start = noise ? 1'($urandom) : 1'b0;
            @(posedge clk); #1;
        end
        bus.start = 1'b0;
    endtask

    task automatic idle(input int n);
        bus.start = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        total     = 0;
        bad       = 0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.din   = 4'd0;
        bus.amt   = 2'd0;
        bus.dir   = 1'b0;
        bus.rot   = 1'b0;
        bus.arith = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", int'(bus.busy), 0);
        check("rst_done", int'(bus.done), 0);
        check("rst_dout", int'(bus.dout), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // directed cases
        issue(4'b0001, 3, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(3);
        issue(4'b1011, 1, 1'b1, 1'b1, 1'b0, 1'b0);
        idle(1);
        issue(4'b1011, 3, 1'b1, 1'b1, 1'b0, 1'b0);
        idle(1);
        issue(4'b1111, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(1);
        issue(4'b0101, 2, 1'b1, 1'b0, 1'b0, 1'b1);
        issue(4'b0001, 1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(2);
        issue(4'b1000, 2, 1'b1, 1'b0, 1'b1, 1'b0);
        idle(2);
        issue(4'b1001, 2, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(2);

        // reset in the middle of an operation: no result may appear
        bus.start = 1'b1;
        bus.din   = 4'b0110;
        bus.amt   = 2'd3;
        bus.dir   = 1'b0;
        bus.rot   = 1'b0;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        check("busy_before_abort", int'(bus.busy), 1);
        rst_n = 1'b0;
        #1;
        check("abort_busy", int'(bus.busy), 0);
        check("abort_done", int'(bus.done), 0);
        check("abort_dout", int'(bus.dout), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(6);
        check("post_abort_busy", int'(bus.busy), 0);

        // randomized operations, with back-to-back chaining and idle gaps
        for (int n = 0; n < 300; n++) begin
            issue(4'($urandom), int'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
                  1'($urandom), 1'($urandom));
            if ($urandom_range(0, 1) == 0)
                idle(int'($urandom_range(1, 3)));
        end
        idle(6);
        check("scoreboard_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
